alu_req_arbiter: RTL



---
 rtl/alu_req_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit ALU: registers the granted
// operation onto the ALU, waits ALU_LAT cycles, then returns a tagged response.
module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 1  // supported range 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic [2:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_z,
    input  logic        alu_agtb,
    input  logic        alu_bgta,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic [2:0]  rsp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rr_q, rr_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [2:0]  rsp_flags_q, rsp_flags_d;
    logic        grant;
    logic        xfer;

    // rr only matters on a tie; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? rr_q : req1_valid;
    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant;
    assign xfer       = req0_ready || req1_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    alu_op_d = grant ? req1_op : req0_op;
                    alu_a_d  = grant ? req1_a  : req0_a;
                    alu_b_d  = grant ? req1_b  : req0_b;
                    rsp_id_d = grant;
                    cnt_d    = CNT_INIT;
                    rr_d     = ~grant;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_data_d  = alu_result;
                    rsp_flags_d = {alu_z, alu_agtb, alu_bgta};
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rr_q        <= 1'b0;
            alu_op_q    <= 3'd0;
            alu_a_q     <= 16'd0;
            alu_b_q     <= 16'd0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= 16'd0;
            rsp_flags_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != IDLE);

endmodule
